// File: rtl/abc_pattern_driver.sv
// abc_pattern_driver: exhaustive A/B/C sweep with dwell and D/E capture.
// Build option: ABC_PATTERN_DRIVER_LOOP_EN keeps sweeping while start is held.
module abc_pattern_driver #(
  parameter int unsigned DWELL = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        D,
  input  logic        E,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic [2:0]  idx,
  output logic        busy,
  output logic        done,
  output logic [15:0] resp
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_DONE
  } state_t;

  localparam logic [7:0] LAST = 8'(DWELL - 1);

  state_t      r_state;
  state_t      w_nxt_state;
  logic [7:0]  r_cnt;
  logic [7:0]  w_nxt_cnt;
  logic [2:0]  r_idx;
  logic [2:0]  w_nxt_idx;
  logic        r_busy;
  logic        w_nxt_busy;
  logic        r_done;
  logic        w_nxt_done;
  logic [15:0] r_resp;
  logic [15:0] w_nxt_resp;

  logic        w_last;
  logic        w_end;
  logic        w_wrap;

  assign w_last = (r_cnt == LAST);
  assign w_end  = w_last && (r_idx == 3'd7);

`ifdef ABC_PATTERN_DRIVER_LOOP_EN
  assign w_wrap = w_end && start;
`else
  assign w_wrap = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_resp  <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_idx   <= w_nxt_idx;
      r_busy  <= w_nxt_busy;
      r_done  <= w_nxt_done;
      r_resp  <= w_nxt_resp;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_nxt_state = S_DRIVE;
      end
      S_DRIVE: begin
        if (w_end && !w_wrap) w_nxt_state = S_DONE;
      end
      S_DONE: begin
        w_nxt_state = S_IDLE;
      end
      default: begin
        w_nxt_state = S_IDLE;
      end
    endcase
  end

  // Next values for the registered outputs; D/E only reach resp via a flop.
  always_comb begin
    w_nxt_cnt  = r_cnt;
    w_nxt_idx  = r_idx;
    w_nxt_busy = r_busy;
    w_nxt_done = r_done;
    w_nxt_resp = r_resp;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_nxt_cnt  = '0;
          w_nxt_idx  = '0;
          w_nxt_busy = 1'b1;
          w_nxt_done = 1'b0;
          w_nxt_resp = '0;
        end
      end
      S_DRIVE: begin
        w_nxt_busy = 1'b1;
        w_nxt_done = w_wrap;
        if (w_last) begin
          w_nxt_cnt = '0;
          w_nxt_resp[{r_idx, 1'b0} +: 2] = {D, E};
          if (r_idx != 3'd7) begin
            w_nxt_idx = r_idx + 3'd1;
          end else if (w_wrap) begin
            w_nxt_idx = '0;
          end else begin
            w_nxt_idx  = '0;
            w_nxt_busy = 1'b0;
            w_nxt_done = 1'b1;
          end
        end else begin
          w_nxt_cnt = r_cnt + 8'd1;
        end
      end
      S_DONE: begin
        w_nxt_idx  = '0;
        w_nxt_busy = 1'b0;
        w_nxt_done = 1'b1;
      end
      default: begin
        w_nxt_cnt  = '0;
        w_nxt_idx  = '0;
        w_nxt_busy = 1'b0;
        w_nxt_done = 1'b0;
      end
    endcase
  end

  assign {A, B, C} = r_idx;
  assign idx       = r_idx;
  assign busy      = r_busy;
  assign done      = r_done;
  assign resp      = r_resp;

endmodule
